// File: rtl/fpu_conv_sched_pkg.sv
// Shared definitions for the double-to-int32 conversion scheduler:
// state encoding, default widths and timeout sizing.
package fpu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int DEF_OPW     = 64;
  localparam int DEF_RESW    = 32;
  localparam int DEF_TIMEOUT = 63;
  localparam int MIN_TOCNT_W = 6;

  // Timeout counter is never narrower than MIN_TOCNT_W bits.
  function automatic int tocnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > MIN_TOCNT_W) ? w : MIN_TOCNT_W;
  endfunction

endpackage

// File: rtl/fpu_conv_sched_arb.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping modulo NREQ.
module rr_arbiter
  import fpu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  // Priority search: offset k from ptr, first hit wins.
  always_comb begin : p_search
    logic hit_s;
    grant     = {NREQ{1'b0}};
    grant_idx = {IDW{1'b0}};
    any       = 1'b0;
    hit_s     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        hit_s     = req[i] && !any && (i == ((int'(ptr) + k) % NREQ));
        grant[i]  = grant[i] | hit_s;
        grant_idx = hit_s ? IDW'(i) : grant_idx;
        any       = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/fpu_conv_sched.sv
// Round-robin scheduler sharing one multi-cycle double-to-int32 unit.
// Optional RUN-state abort is enabled by defining FPU_CONV_SCHED_TIMEOUT_EN.
module fpu_conv_sched
  import fpu_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int OPW     = DEF_OPW,
  parameter int RESW    = DEF_RESW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [RESW-1:0]     resp_data,
  output logic                resp_err,
  output logic                unit_en,
  output logic                unit_rst,
  output logic [OPW-1:0]      unit_a,
  input  logic [RESW-1:0]     unit_z,
  input  logic                unit_complete,
  output logic                busy
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_param_check
    $error("fpu_conv_sched: illegal NREQ/IDW/TIMEOUT combination");
  end

  sched_state_t    state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  resp_id_r;
  logic [RESW-1:0] resp_data_r;
  logic            resp_valid_r;
  logic            unit_en_r;
  logic            unit_rst_r;
  logic [OPW-1:0]  unit_a_r;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic            any_s;
  logic [OPW-1:0]  op_mux_s;
  logic [IDW-1:0]  next_ptr_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  // One-hot operand select driven by the arbiter grant.
  always_comb begin
    op_mux_s = {OPW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      op_mux_s = grant_s[i] ? req_data[i*OPW +: OPW] : op_mux_s;
    end
  end

  assign next_ptr_s = (grant_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : grant_idx_s + IDW'(1);

  // Accept pulse only in IDLE; held off while reset is asserted.
  assign req_ready  = (rst && state_r == IDLE) ? grant_s : {NREQ{1'b0}};
  assign busy       = (state_r != IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;
  assign unit_en    = unit_en_r;
  assign unit_rst   = unit_rst_r;
  assign unit_a     = unit_a_r;

`ifdef FPU_CONV_SCHED_TIMEOUT_EN
  localparam int CNTW = tocnt_width(TIMEOUT);
  logic [CNTW-1:0] cnt_r;
  logic            resp_err_r;
  assign resp_err = resp_err_r;
`else
  assign resp_err = 1'b0;
`endif

  // Scheduler FSM with operand/result latches and unit handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= {IDW{1'b0}};
      resp_id_r    <= {IDW{1'b0}};
      resp_data_r  <= {RESW{1'b0}};
      resp_valid_r <= 1'b0;
      unit_en_r    <= 1'b0;
      unit_rst_r   <= 1'b0;
      unit_a_r     <= {OPW{1'b0}};
`ifdef FPU_CONV_SCHED_TIMEOUT_EN
      cnt_r        <= {CNTW{1'b0}};
      resp_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            unit_a_r   <= op_mux_s;
            resp_id_r  <= grant_idx_s;
            rr_ptr_r   <= next_ptr_s;
            unit_en_r  <= 1'b1;
            unit_rst_r <= 1'b1;
            state_r    <= CLEAR;
          end
        end
        CLEAR: begin
          unit_rst_r <= 1'b0;
`ifdef FPU_CONV_SCHED_TIMEOUT_EN
          cnt_r      <= {CNTW{1'b0}};
`endif
          state_r    <= RUN;
        end
        RUN: begin
          if (unit_complete) begin
            resp_data_r  <= unit_z;
            resp_valid_r <= 1'b1;
            unit_en_r    <= 1'b0;
`ifdef FPU_CONV_SCHED_TIMEOUT_EN
            resp_err_r   <= 1'b0;
`endif
            state_r      <= RESP;
          end
`ifdef FPU_CONV_SCHED_TIMEOUT_EN
          else if (cnt_r == CNTW'(TIMEOUT - 1)) begin
            // Abort: dropping en lets the unit start clean on the next CLEAR.
            resp_data_r  <= {RESW{1'b0}};
            resp_err_r   <= 1'b1;
            resp_valid_r <= 1'b1;
            unit_en_r    <= 1'b0;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r + CNTW'(1);
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
